// File: rtl/prescaler_tick_ctrl_pkg.sv
// Shared constants for the prescaler tick controller: register map, bit positions,
// FSM state encoding and default widths.
package prescaler_tick_pkg;

  localparam int PRESCALE_W_DEF = 28;
  localparam int COUNT_W_DEF    = 32;
  localparam int AVS_ADDR_W     = 2;
  localparam int AVS_DATA_W     = 32;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_COUNT   = 2'd2;
  localparam logic [1:0] ADDR_CURRENT = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_ONE_SHOT  = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_CLR_COUNT = 3;

  localparam int STAT_RUNNING    = 0;
  localparam int STAT_TICK_PEND  = 1;
  localparam int STAT_COUNT_WRAP = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/prescaler_tick_ctrl_if.sv
// Avalon-MM slave bus of the prescaler tick controller.
interface prescaler_tick_ctrl_if;
  import prescaler_tick_pkg::*;

  logic [AVS_ADDR_W-1:0] avs_s0_address;
  logic                  avs_s0_read;
  logic                  avs_s0_write;
  logic [AVS_DATA_W-1:0] avs_s0_writedata;
  logic [AVS_DATA_W-1:0] avs_s0_readdata;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata
  );
endinterface

// File: rtl/prescaler_tick_ctrl_down_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement.
module prescale_down_counter
  import prescaler_tick_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  dec,
  input  logic [PRESCALE_W-1:0] load_val,
  output logic [PRESCALE_W-1:0] count,
  output logic                  zero
);

  logic [PRESCALE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - PRESCALE_W'(1);
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/prescaler_tick_ctrl.sv
// Prescaler tick controller: IDLE/LOAD/RUN sequencer around a down-counter, with a
// CTRL/STATUS/COUNT/CURRENT register file behind an Avalon-MM slave.
module prescaler_tick_ctrl
  import prescaler_tick_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int COUNT_W    = COUNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  prescaler_tick_ctrl_if.slave  bus,
  input  logic [PRESCALE_W-1:0] prescale_in,
  output logic                  tick,
  output logic                  irq
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_RUN  = ST_RUN;

  logic [1:0]            state_q, state_d;
  logic                  enable_q, one_shot_q, irq_en_q;
  logic                  tick_pending_q, count_wrap_q;
  logic [COUNT_W-1:0]    count_q;
  logic [31:0]           rdata_p1, rd_mux;
  logic [PRESCALE_W-1:0] cnt;
  logic                  cnt_zero, cnt_load, cnt_dec;
  logic                  ctrl_wr, status_wr, dis_wr, clr, terminal, wrap_set;
  logic [31:0]           wd;
  logic [27:0]           unused_wd;

  assign wd        = bus.avs_s0_writedata;
  assign unused_wd = wd[31:4];
  assign ctrl_wr   = bus.avs_s0_write && (bus.avs_s0_address == ADDR_CTRL);
  assign status_wr = bus.avs_s0_write && (bus.avs_s0_address == ADDR_STATUS);
  assign clr       = ctrl_wr && wd[CTRL_CLR_COUNT];

  // A disabling write outranks a terminal count landing in the same cycle.
  assign dis_wr   = ctrl_wr && !wd[CTRL_ENABLE] && (state_q != S_IDLE);
  assign terminal = (state_q == S_RUN) && cnt_zero;
  assign tick     = terminal && !dis_wr;
  assign wrap_set = tick && !clr && (&count_q);
  assign irq      = irq_en_q && tick_pending_q;

  // Periodic reload samples prescale_in only at terminal count.
  assign cnt_load = (state_q == S_LOAD) || (tick && !one_shot_q);
  assign cnt_dec  = (state_q == S_RUN) && !cnt_zero;

  prescale_down_counter #(.PRESCALE_W(PRESCALE_W)) u_down_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (prescale_in),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_wr && wd[CTRL_ENABLE]) state_d = S_LOAD;
      S_LOAD:  state_d = dis_wr ? S_IDLE : S_RUN;
      S_RUN:   if (dis_wr || (tick && one_shot_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      enable_q       <= 1'b0;
      one_shot_q     <= 1'b0;
      irq_en_q       <= 1'b0;
      tick_pending_q <= 1'b0;
      count_wrap_q   <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl_wr) begin
        enable_q   <= wd[CTRL_ENABLE];
        one_shot_q <= wd[CTRL_ONE_SHOT];
        irq_en_q   <= wd[CTRL_IRQ_EN];
      end
      if (tick && one_shot_q) enable_q <= 1'b0;

      if (clr)       count_q <= '0;
      else if (tick) count_q <= count_q + COUNT_W'(1);

      // Hardware set wins over a software W1C in the same cycle.
      if (tick)                                 tick_pending_q <= 1'b1;
      else if (status_wr && wd[STAT_TICK_PEND]) tick_pending_q <= 1'b0;
      if (wrap_set)                              count_wrap_q <= 1'b1;
      else if (status_wr && wd[STAT_COUNT_WRAP]) count_wrap_q <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.avs_s0_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_ENABLE]   = enable_q;
        rd_mux[CTRL_ONE_SHOT] = one_shot_q;
        rd_mux[CTRL_IRQ_EN]   = irq_en_q;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_RUNNING]    = (state_q != S_IDLE);
        rd_mux[STAT_TICK_PEND]  = tick_pending_q;
        rd_mux[STAT_COUNT_WRAP] = count_wrap_q;
      end
      ADDR_COUNT: rd_mux = 32'(count_q);
      default:    rd_mux = 32'(cnt);
    endcase
  end

  // Read data stage: one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_p1 <= '0;
    end else if (bus.avs_s0_read) begin
      rdata_p1 <= rd_mux;
    end
  end

  assign bus.avs_s0_readdata = rdata_p1;

endmodule

// File: doc/prescaler_tick_ctrl.md
# prescaler_tick_ctrl

Sequences the 28-bit prescaler value held by the prescaler register block: loads it into a down-counter, emits a one-cycle `tick` at each terminal count, and runs in periodic or one-shot mode under software control. Sits between the prescaler register block (source of `prescale_in`) and downstream timed logic (LED blinkers, sampling strobes). Software controls it through its own Avalon-MM slave and can take an interrupt on ticks.

## Interface
- `PRESCALE_W`, 28: width of prescaler value and down-counter.
- `COUNT_W`, 32: width of tick counter.
- `clk` in 1: single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `avs_s0_address` in 2: register select (0 CTRL, 1 STATUS, 2 COUNT, 3 CURRENT).
- `avs_s0_read` in 1: read strobe.
- `avs_s0_write` in 1: write strobe.
- `avs_s0_writedata` in 32: write data.
- `avs_s0_readdata` out 32: registered read data, fixed read latency 1.
- `prescale_in` in PRESCALE_W: reload value from the prescaler register block.
- `tick` out 1: one-cycle pulse at terminal count.
- `irq` out 1: level interrupt, `irq_en & tick_pending`.

## Operation
- CTRL (RW): bit0 `enable`, bit1 `one_shot`, bit2 `irq_en`, bit3 `clr_count` (write-1 action, reads 0).
- STATUS (RO except W1C): bit0 `running` (state != IDLE), bit1 `tick_pending` (W1C), bit2 `count_wrap` (W1C).
- COUNT (RO): ticks since reset or since `clr_count`; wraps modulo 2^COUNT_W, setting `count_wrap`.
- CURRENT (RO): down-counter value, zero-extended.
- FSM states are IDLE, LOAD, RUN.
- IDLE: counter holds. A write setting `enable=1` moves the FSM to LOAD.
- LOAD: lasts one cycle. Counter <= `prescale_in`, then go to RUN.
- RUN with counter != 0: decrement.
- RUN with counter == 0: `tick`=1, COUNT+1, `tick_pending` set.
  - Periodic mode: counter <= `prescale_in`, sampled in that cycle, so a changed prescaler takes effect only at a terminal count.
  - One-shot mode: clear `enable` and go to IDLE.
- A CTRL write with `enable=0` in LOAD or RUN goes to IDLE next cycle. A write with `enable=1` while running does not restart.
- Same-cycle collisions:
  - A disabling CTRL write in the same cycle as a terminal count has priority. `tick` is suppressed, COUNT unchanged.
  - A `tick_pending` set and W1C in the same cycle: set wins. Same for `count_wrap`.
  - `clr_count` in the same cycle as a tick: COUNT becomes 0.
- Reads of unused bits return 0. Writes to STATUS bits other than W1C, and to COUNT/CURRENT, are ignored.

## Timing
- Reset values: `tick`=0, `irq`=0, `avs_s0_readdata`=0, CTRL=0, STATUS=0, COUNT=0, counter=0, state IDLE.
- Enable write in cycle 0:
  - LOAD in cycle 1.
  - Counter = P in cycle 2.
  - First `tick` in cycle P+2.
- Subsequent ticks every P+1 cycles.
- P=0 gives `tick` in every RUN cycle.
- COUNT and `tick_pending` update the cycle after `tick`. `irq` asserts the same cycle as `tick_pending`.
- Readdata is valid the cycle after `avs_s0_read`.
- A reset assertion mid-run forces IDLE immediately (async). `tick` drops without a glitch-free guarantee beyond the register output.

## Structure
- Package `prescaler_tick_pkg`: register address constants, CTRL/STATUS bit index constants, `state_t` enum (IDLE, LOAD, RUN), default widths.
- Sub-module `prescale_down_counter`: load/decrement/zero-flag, parameterized by PRESCALE_W.
- Top module holds the FSM, register file and read mux.

## Test plan
- Periodic run: `prescale_in`=3, write CTRL=0x1 -> first tick in cycle 5, then ticks every 4 cycles; COUNT=3 after third tick.
- One-shot: `prescale_in`=2, CTRL=0x3 -> single tick in cycle 4; STATUS.running=0 and CTRL.enable=0 afterward; no further ticks over 20 cycles.
- Reload shadowing: P=5, change `prescale_in` to 1 mid-period -> current period completes at 6 cycles, later periods are 2 cycles.
- Interrupt: CTRL=0x5, P=0 -> `irq` high after first tick. Write STATUS=0x2 while ticks continue -> `tick_pending` stays 1 (set wins). Disable, then W1C -> `irq`=0.
- Collision: disabling write in the exact terminal-count cycle -> no tick, COUNT unchanged, IDLE next cycle.
- Async reset: assert `reset_n`=0 mid-RUN with counter=7 -> all outputs and registers at reset values immediately. Release -> IDLE, no tick until re-enabled.
